demux16_router: RTL and testbench

//  Inverse of the 16-bit 2:1 result mux. Accepts one 16-bit word stream with a
//  per-word select and steers each word to destination A (sel=0) or B (sel=1).

---
 rtl/dlx_pkg.sv | 15 +
 rtl/demux16_router_if.sv | 37 +++
 rtl/demux_fifo.sv | 65 ++++++
 rtl/demux16_router.sv | 97 +++++++++
 tb/tb_demux16_router.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX datapath definitions: word width, demux select encodings and the
// odd-parity check used on result-bus words.
package dlx_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // A word is good when data plus its parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [WORD_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/demux16_router_if.sv
// Bundle of the router's input stream, both destination streams and status outputs.
// The router takes the slave view; the producer/consumer side takes the master view.
interface demux16_router_if
    import dlx_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_sel;
    logic              in_par;

    logic              a_valid;
    logic              a_ready;
    logic [WORD_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [WORD_W-1:0] b_data;

    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  err_cnt;
    logic              par_err;

    modport master (
        output in_valid, in_data, in_sel, in_par, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b, err_cnt, par_err
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_par, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, cnt_a, cnt_b, err_cnt, par_err
    );

endinterface

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with registered storage; dout always shows the head entry.
// Push is ignored when full and pop is ignored when empty.
module demux_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/demux16_router.sv
// Steers a parity-checked 16-bit word stream into per-destination FIFOs (A/B),
// with saturating routed-word and parity-error counters and a sticky error flag.
module demux16_router
    import dlx_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    demux16_router_if.slave bus
);

    logic             a_full;
    logic             a_empty;
    logic             b_full;
    logic             b_empty;
    logic             accept;
    logic             good;
    logic             push_a;
    logic             push_b;
    logic             bad;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             par_err_q;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Ready looks only at pre-pop fullness of the selected FIFO, so a stalled
    // word also blocks later words headed for the other destination.
    assign bus.in_ready = (bus.in_sel == SEL_B) ? ~b_full : ~a_full;
    assign accept       = bus.in_valid & bus.in_ready;
    assign good         = odd_parity_ok(bus.in_data, bus.in_par);
    assign push_a       = accept & good & (bus.in_sel == SEL_A);
    assign push_b       = accept & good & (bus.in_sel == SEL_B);
    assign bad          = accept & ~good;

    demux_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a),
        .din   (bus.in_data),
        .pop   (bus.a_ready),
        .dout  (bus.a_data),
        .full  (a_full),
        .empty (a_empty)
    );

    demux_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b),
        .din   (bus.in_data),
        .pop   (bus.b_ready),
        .dout  (bus.b_data),
        .full  (b_full),
        .empty (b_empty)
    );

    assign bus.a_valid = ~a_empty;
    assign bus.b_valid = ~b_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            err_cnt_q <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (push_a && cnt_a_q != '1) begin
                cnt_a_q <= cnt_a_q + CNT_ONE;
            end
            if (push_b && cnt_b_q != '1) begin
                cnt_b_q <= cnt_b_q + CNT_ONE;
            end
            if (bad) begin
                par_err_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.cnt_a   = cnt_a_q;
    assign bus.cnt_b   = cnt_b_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.par_err = par_err_q;

endmodule

// File: tb/tb_demux16_router.sv
// Scoreboard bench for demux16_router: directed words queue their expected
// destination output, and a negedge monitor compares each popped head word.
module tb_demux16_router;
    import dlx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux16_router_if #(.CNT_W(8)) bus ();
    demux16_router_if #(.CNT_W(2)) sbus ();

    demux16_router #(.DEPTH(2), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    demux16_router #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic gpar(input logic [15:0] d);
        return ~(^d);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic s, input logic p);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_par   = p;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (^{d, p}) begin
                    if (s) exp_b.push_back(d);
                    else   exp_a.push_back(d);
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: word %h not accepted in 50 cycles, expected acceptance", d);
        end
    endtask

    // Monitor: every pop on a destination port must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.a_valid && bus.a_ready) begin
                if (exp_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_extra: got word %h, expected no word", bus.a_data);
                end else begin
                    check("a_data", {16'h0, bus.a_data}, {16'h0, exp_a.pop_front()});
                end
            end
            if (bus.b_valid && bus.b_ready) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_extra: got word %h, expected no word", bus.b_data);
                end else begin
                    check("b_data", {16'h0, bus.b_data}, {16'h0, exp_b.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = 1'b0;
        bus.in_par    = 1'b0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        sbus.in_valid = 1'b0;
        sbus.in_data  = '0;
        sbus.in_sel   = 1'b0;
        sbus.in_par   = 1'b0;
        sbus.a_ready  = 1'b1;
        sbus.b_ready  = 1'b1;

        // Reset state
        idle(2);
        @(negedge clk);
        check("rst_a_valid", bus.a_valid, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_a_data", bus.a_data, 0);
        check("rst_b_data", bus.b_data, 0);
        check("rst_cnt_a", bus.cnt_a, 0);
        check("rst_cnt_b", bus.cnt_b, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_par_err", bus.par_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: fill A, then reset mid-stream
        bus.b_ready = 1'b1;
        send(16'h1111, SEL_A, gpar(16'h1111));
        send(16'h2222, SEL_A, gpar(16'h2222));
        check("t1_a_valid_full", bus.a_valid, 1);
        check("t1_cnt_a_full", bus.cnt_a, 2);
        check("t1_in_ready_full", bus.in_ready, 0);
        reset = 1'b1;
        #1;
        check("t1_a_valid_rst", bus.a_valid, 0);
        check("t1_cnt_a_rst", bus.cnt_a, 0);
        check("t1_in_ready_rst", bus.in_ready, 1);
        exp_a.delete();
        exp_b.delete();
        idle(1);
        reset = 1'b0;

        // 2: alternate destinations, both consumers ready
        bus.a_ready = 1'b1;
        send(16'h1234, SEL_A, 1'b0);
        check("t2_a_valid_lat", bus.a_valid, 1);
        check("t2_a_data_lat", bus.a_data, 16'h1234);
        send(16'hABCD, SEL_B, 1'b1);
        check("t2_b_valid_lat", bus.b_valid, 1);
        check("t2_b_data_lat", bus.b_data, 16'hABCD);
        idle(2);
        check("t2_cnt_a", bus.cnt_a, 1);
        check("t2_cnt_b", bus.cnt_b, 1);

        // 3: B stalled, third B word blocks a following A word
        bus.b_ready = 1'b0;
        send(16'h00B1, SEL_B, gpar(16'h00B1));
        send(16'h00B2, SEL_B, gpar(16'h00B2));
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00B3;
        bus.in_sel   = SEL_B;
        bus.in_par   = gpar(16'h00B3);
        @(negedge clk);
        check("t3_stall_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_stall_ready2", bus.in_ready, 0);
        check("t3_a_waits", bus.a_valid, 0);
        check("t3_b_head", bus.b_data, 16'h00B1);
        @(posedge clk);
        #1;
        bus.b_ready = 1'b1;
        send(16'h00B3, SEL_B, gpar(16'h00B3));
        send(16'h00A1, SEL_A, gpar(16'h00A1));
        idle(3);
        check("t3_cnt_a", bus.cnt_a, 2);
        check("t3_cnt_b", bus.cnt_b, 4);

        // 4: full B with same-cycle pop: no ready-through, accepted next cycle
        bus.b_ready = 1'b0;
        send(16'h00C1, SEL_B, gpar(16'h00C1));
        send(16'h00C2, SEL_B, gpar(16'h00C2));
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00C3;
        bus.in_sel   = SEL_B;
        bus.in_par   = gpar(16'h00C3);
        bus.b_ready  = 1'b1;
        @(negedge clk);
        check("t4_no_ready_through", bus.in_ready, 0);
        check("t4_b_head", bus.b_data, 16'h00C1);
        @(posedge clk);
        #1;
        check("t4_ready_after_pop", bus.in_ready, 1);
        send(16'h00C3, SEL_B, gpar(16'h00C3));
        idle(3);
        check("t4_cnt_b", bus.cnt_b, 7);

        // 5: bad parity word is dropped and flagged
        send(16'h0001, SEL_A, 1'b1);
        check("t5_no_a_valid", bus.a_valid, 0);
        check("t5_err_cnt", bus.err_cnt, 1);
        check("t5_par_err", bus.par_err, 1);
        check("t5_cnt_a", bus.cnt_a, 2);
        send(16'h0003, SEL_A, 1'b1);
        idle(2);
        check("t5_par_err_sticky", bus.par_err, 1);
        check("t5_err_cnt_hold", bus.err_cnt, 1);
        check("t5_cnt_a_good", bus.cnt_a, 3);

        // 6: two-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            sbus.in_valid = 1'b1;
            sbus.in_data  = 16'h0010 + 16'(i);
            sbus.in_sel   = SEL_A;
            sbus.in_par   = gpar(16'h0010 + 16'(i));
            @(negedge clk);
            check("t6_in_ready", sbus.in_ready, 1);
            @(posedge clk);
            #1;
            check("t6_cnt_a", sbus.cnt_a, (i + 1 > 3) ? 3 : i + 1);
        end
        sbus.in_valid = 1'b0;

        idle(5);
        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
